level_ctrl: RTL and testbench
=============================

LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, score input width in bits.
REQ-002 SHALL have parameter MAX_LEVEL, default 5, highest reachable level (1..15).
REQ-003 SHALL have parameter FIRST_SCORE, default 10, score that reaches level 1.
REQ-004 SHALL have parameter STEP_SCORE, default 10, score increment per further level.
REQ-005 SHALL have parameters BASE_DIV, default 16, and DIV_STEP, default 2, speed-divisor base and per-level decrement.
REQ-006 SHALL have parameter FLASH_HALF, default 25000000, flash half-period in cycles (used only with LEVEL_FLASH_EN).
REQ-007 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: enable  in  1  clock-enable; start  in  1  start/restart request; collision  in  1  game-over event.
REQ-009 SHALL have ports: score  in  SCORE_W  current score; level  out  LEVEL_W (=4)  current level.
REQ-010 SHALL have ports: level_up  out  1  one-cycle increment pulse; game_over  out  1  high in OVER state.
REQ-011 SHALL have ports: speed_div  out  8  obstacle-speed divisor; hex_level  out  7 ([0:6])  active-low level digit.

Function
REQ-012 SHALL implement FSM states IDLE, PLAY, OVER; transitions IDLE->PLAY on start, PLAY->OVER on collision, OVER->IDLE on start.
REQ-013 SHALL hold all state, level and pulses unchanged on any cycle with enable low; level_up SHALL be 0 such cycles.
REQ-014 SHALL define threshold(k) = FIRST_SCORE + (k-1)*STEP_SCORE for k = 1..MAX_LEVEL, computed at SCORE_W+5 bits, no overflow.
REQ-015 SHALL compute target = count of k with score >= threshold(k) each PLAY cycle.
REQ-016 SHALL, when target > level in PLAY, increment level by exactly 1 and assert level_up for that one cycle; multi-level jumps take consecutive cycles.
REQ-017 SHALL never decrement level in PLAY when score falls; level saturates at MAX_LEVEL.
REQ-018 SHALL give collision priority over increment in the same cycle: go to OVER, no increment, level_up 0.
REQ-019 SHALL freeze level in OVER; transition OVER->IDLE SHALL clear level to 0.
REQ-020 SHALL register speed_div = max(BASE_DIV - level*DIV_STEP, 1), updated the cycle after level changes.
REQ-021 SHALL decode level combinationally to hex_level, patterns 0..F active-low (0 = 7'b0000001), values >15 all ones.

Reset
REQ-022 SHALL, on reset high (asynchronous), force state IDLE, level 0, level_up 0, game_over 0, speed_div BASE_DIV, flash counters 0.
REQ-023 SHALL abort any mid-operation activity on reset, including a multi-cycle level climb or flash; no pulse on release.

Configuration
REQ-024 SHALL, with LEVEL_FLASH_EN defined, blank hex_level (all ones) on alternate FLASH_HALF-cycle periods for 4 half-periods after each level_up, restarting on a new level_up.
REQ-025 SHALL, without LEVEL_FLASH_EN, drive hex_level steadily from level and contain no flash counter logic.

Structure
REQ-026 SHALL place state enum, LEVEL_W, seven-segment pattern constants and the threshold function in package level_pkg.
REQ-027 SHALL instantiate one sub-module seg7_decoder (4-bit in, active-low [0:6] out) for hex_level.

Verification
REQ-028 SHALL cover: reset, start, score 0->10 -> level 1 and one level_up pulse one cycle after score reaches 10, speed_div 14.
REQ-029 SHALL cover: PLAY at level 0, score jumps to 45 -> level 1,2,3,4 on four consecutive cycles, four level_up pulses.
REQ-030 SHALL cover: level 5, score 200 -> level stays 5, no level_up; speed_div 6.
REQ-031 SHALL cover: collision and score crossing 20 same cycle at level 1 -> OVER, level 1, game_over 1, no pulse; start -> IDLE, level 0.
REQ-032 SHALL cover: enable low while score crosses 30 -> no change; enable high -> increment next cycle.
REQ-033 SHALL cover: reset asserted mid-climb (level 2 of 4) -> immediate level 0, IDLE; with LEVEL_FLASH_EN and FLASH_HALF=4, level_up -> hex_level blank cycles 1-4, digit 5-8, blank 9-12, digit 13-16, steady thereafter.

Source files
------------

// File: rtl/level_pkg.sv
// Shared types and constants for the level controller: FSM states, level width,
// active-low seven-segment patterns ([0:6] = segments a..g) and the score threshold.
package level_pkg;

    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Score needed to reach level k (k >= 1); 64-bit so no parameter set can overflow it.
    function automatic logic [63:0] threshold(input int k, input int first, input int step);
        return 64'(first) + 64'(k - 1) * 64'(step);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low seven-segment pattern, segment a at index 0.
module seg7_decoder
    import level_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [0:6] o_seg
);

    // Pure lookup; blank is the fallback pattern.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/level_ctrl.sv
// Game level controller: climbs one level per cycle toward the score-derived
// target while playing, freezes on collision, clears on restart.
// Optional macro LEVEL_FLASH_EN blinks the level digit after each level-up.
//
// state   | meaning
// --------+------------------------------------------
// ST_IDLE | waiting for start, level held at 0
// ST_PLAY | game running, level follows score upward
// ST_OVER | collision seen, level frozen until start
module level_ctrl
    import level_pkg::*;
#(
    parameter int SCORE_W     = 16,
    parameter int MAX_LEVEL   = 5,
    parameter int FIRST_SCORE = 10,
    parameter int STEP_SCORE  = 10,
    parameter int BASE_DIV    = 16,
    parameter int DIV_STEP    = 2,
    parameter int FLASH_HALF  = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic               collision,
    input  logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic               level_up,
    output logic               game_over,
    output logic [7:0]         speed_div,
    output logic [0:6]         hex_level
);

    localparam int TW = SCORE_W + 5;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_target;
    logic               r_level_up;
    logic               w_inc;
    logic               w_clear;
    logic [7:0]         r_speed_div;
    int                 w_div_calc;
    logic [TW-1:0]      w_score_ext;
    logic [0:6]         w_seg;

    assign w_score_ext = TW'(score);

    // Number of thresholds the current score meets; thresholds are monotone so this is the target level.
    always_comb begin
        w_target = '0;
        for (int k = 1; k <= MAX_LEVEL; k++) begin
            if (w_score_ext >= TW'(threshold(k, FIRST_SCORE, STEP_SCORE)))
                w_target = w_target + LEVEL_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus level increment/clear decisions; collision beats increment.
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_clear     = 1'b0;
        if (enable) begin
            case (r_state)
                ST_IDLE: if (start) w_state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (collision)
                        w_state_nxt = ST_OVER;
                    else if ((w_target > r_level) && (r_level < LEVEL_W'(MAX_LEVEL)))
                        w_inc = 1'b1;
                end
                ST_OVER: begin
                    if (start) begin
                        w_state_nxt = ST_IDLE;
                        w_clear     = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_div_calc = BASE_DIV - DIV_STEP * int'(r_level);

    // Level, its one-cycle pulse, and the speed divisor trailing the level by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level     <= '0;
            r_level_up  <= 1'b0;
            r_speed_div <= 8'(BASE_DIV);
        end else begin
            r_level_up  <= w_inc;
            r_speed_div <= (w_div_calc < 1) ? 8'd1 : w_div_calc[7:0];
            if (w_clear)    r_level <= '0;
            else if (w_inc) r_level <= r_level + LEVEL_W'(1);
        end
    end

    seg7_decoder u_seg7 (
        .i_digit (r_level),
        .o_seg   (w_seg)
    );

`ifdef LEVEL_FLASH_EN
    localparam int FC_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [FC_W-1:0] r_flash_cnt;
    logic [2:0]      r_flash_half;
    logic            w_blank;

    // Four half-periods of blink after each increment; a new increment restarts the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_cnt  <= '0;
            r_flash_half <= '0;
        end else if (w_inc) begin
            r_flash_cnt  <= FC_W'(FLASH_HALF - 1);
            r_flash_half <= 3'd4;
        end else if (r_flash_half != 3'd0) begin
            if (r_flash_cnt == '0) begin
                r_flash_cnt  <= FC_W'(FLASH_HALF - 1);
                r_flash_half <= r_flash_half - 3'd1;
            end else begin
                r_flash_cnt <= r_flash_cnt - FC_W'(1);
            end
        end
    end

    // Blank on the 4th and 2nd remaining half-periods.
    assign w_blank   = (r_flash_half != 3'd0) && !r_flash_half[0];
    assign hex_level = w_blank ? SEG_BLANK : w_seg;
`else
    logic w_unused_flash_half;
    assign w_unused_flash_half = ^FLASH_HALF;
    assign hex_level           = w_seg;
`endif

    assign level     = r_level;
    assign level_up  = r_level_up;
    assign speed_div = r_speed_div;
    assign game_over = (r_state == ST_OVER);

endmodule

// File: tb/tb_level_ctrl.sv
// Scoreboard bench for level_ctrl: each driven cycle pushes the expected
// post-edge outputs; a monitor pops and compares on every falling edge.
module tb_level_ctrl;

    typedef struct {
        logic [3:0] lvl;
        logic       up;
        logic       go;
        logic [7:0] div;
        logic [0:6] hex;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        start;
    logic        collision;
    logic [15:0] score;
    logic [3:0]  level;
    logic        level_up;
    logic        game_over;
    logic [7:0]  speed_div;
    logic [0:6]  hex_level;

    exp_t  q[$];
    string qn[$];
    exp_t  mon_e;
    string mon_n;
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    blank_nxt = 1'b0;
`ifdef LEVEL_FLASH_EN
    bit    hex_chk = 1'b0;
`else
    bit    hex_chk = 1'b1;
`endif

    logic [0:6] tb_seg [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    level_ctrl #(
        .SCORE_W     (16),
        .MAX_LEVEL   (5),
        .FIRST_SCORE (10),
        .STEP_SCORE  (10),
        .BASE_DIV    (16),
        .DIV_STEP    (2),
        .FLASH_HALF  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .collision (collision),
        .score     (score),
        .level     (level),
        .level_up  (level_up),
        .game_over (game_over),
        .speed_div (speed_div),
        .hex_level (hex_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
    task automatic step(input logic en, input logic st, input logic col, input logic [15:0] sc,
                        input logic [3:0] el, input logic eu, input logic eg, input logic [7:0] ed,
                        input string nm);
        exp_t e;
        logic [3:0] idx;
        @(negedge clk);
        enable    = en;
        start     = st;
        collision = col;
        score     = sc;
        @(posedge clk);
        idx   = el;
        e.lvl = el;
        e.up  = eu;
        e.go  = eg;
        e.div = ed;
        e.hex = blank_nxt ? 7'b1111111 : tb_seg[idx];
        q.push_back(e);
        qn.push_back(nm);
    endtask

    // Monitor: compare queued expectations against the DUT on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                mon_n = qn.pop_front();
                chk({mon_n, ".level"},     32'(level),     32'(mon_e.lvl));
                chk({mon_n, ".level_up"},  32'(level_up),  32'(mon_e.up));
                chk({mon_n, ".game_over"}, 32'(game_over), 32'(mon_e.go));
                chk({mon_n, ".speed_div"}, 32'(speed_div), 32'(mon_e.div));
                if (hex_chk)
                    chk({mon_n, ".hex"},   32'(hex_level), 32'(mon_e.hex));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; start = 1'b0; collision = 1'b0; score = '0;
        #23 reset = 1'b0;

        // reset state, then start and first level at score 10
        step(0, 0, 0,   0, 0, 0, 0, 16, "rst_state");
        step(1, 1, 0,   0, 0, 0, 0, 16, "start");
        step(1, 0, 0,   0, 0, 0, 0, 16, "play_l0");
        step(1, 0, 0,  10, 1, 1, 0, 16, "reach10");
        step(1, 0, 0,  10, 1, 0, 0, 14, "l1_hold");
        step(1, 0, 0,  10, 1, 0, 0, 14, "l1_div");

        // collision wins over crossing 20
        step(1, 0, 1,  20, 1, 0, 1, 14, "col_vs_inc");
        step(1, 0, 0,  20, 1, 0, 1, 14, "over_frozen");
        step(1, 1, 0,  20, 0, 0, 0, 14, "over_to_idle");
        step(1, 0, 0,   0, 0, 0, 0, 16, "idle_l0");

        // jump to 45 climbs one level per cycle
        step(1, 1, 0,   0, 0, 0, 0, 16, "restart");
        step(1, 0, 0,  45, 1, 1, 0, 16, "climb1");
        step(1, 0, 0,  45, 2, 1, 0, 14, "climb2");
        step(1, 0, 0,  45, 3, 1, 0, 12, "climb3");
        step(1, 0, 0,  45, 4, 1, 0, 10, "climb4");
        step(1, 0, 0,  45, 4, 0, 0,  8, "climb_stop");

        // saturation at 5 and no decrement
        step(1, 0, 0, 200, 5, 1, 0,  8, "to_l5");
        step(1, 0, 0, 200, 5, 0, 0,  6, "sat5_a");
        step(1, 0, 0, 200, 5, 0, 0,  6, "sat5_b");
        step(1, 0, 0,   0, 5, 0, 0,  6, "no_decr");
        step(1, 0, 1,   0, 5, 0, 1,  6, "over_l5");
        step(1, 1, 0,   0, 0, 0, 0,  6, "idle_from5");
        step(1, 0, 0,   0, 0, 0, 0, 16, "idle_div");

        // enable low holds everything while score crosses 30
        step(1, 1, 0,   0, 0, 0, 0, 16, "start3");
        step(1, 0, 0,  25, 1, 1, 0, 16, "s25_a");
        step(1, 0, 0,  25, 2, 1, 0, 14, "s25_b");
        step(1, 0, 0,  25, 2, 0, 0, 12, "s25_hold");
        step(0, 0, 0,  30, 2, 0, 0, 12, "en_low_a");
        step(0, 0, 0,  30, 2, 0, 0, 12, "en_low_b");
        step(0, 0, 1,  30, 2, 0, 0, 12, "en_low_col");
        step(1, 0, 0,  30, 3, 1, 0, 12, "en_high");
        step(1, 0, 0,  30, 3, 0, 0, 10, "en_high_hold");

        // reset in the middle of a climb toward 4
        step(1, 0, 1,  30, 3, 0, 1, 10, "over_l3");
        step(1, 1, 0,   0, 0, 0, 0, 10, "idle4");
        step(1, 1, 0,   0, 0, 0, 0, 16, "start4");
        step(1, 0, 0,  45, 1, 1, 0, 16, "mid_climb1");
        step(1, 0, 0,  45, 2, 1, 0, 14, "mid_climb2");
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst.level",     32'(level),     32'd0);
        chk("async_rst.level_up",  32'(level_up),  32'd0);
        chk("async_rst.game_over", 32'(game_over), 32'd0);
        chk("async_rst.speed_div", 32'(speed_div), 32'd16);
        step(1, 0, 0,  45, 0, 0, 0, 16, "rst_held");
        #2 reset = 1'b0;
        step(1, 0, 0,  45, 0, 0, 0, 16, "post_rst_a");
        step(1, 0, 0,  45, 0, 0, 0, 16, "post_rst_b");

`ifdef LEVEL_FLASH_EN
        // blink pattern after a level-up with a 4-cycle half-period
        @(negedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        hex_chk = 1'b1;
        step(1, 1, 0,   0, 0, 0, 0, 16, "fl_start");
        blank_nxt = 1'b1;
        step(1, 0, 0,  10, 1, 1, 0, 16, "fl_up");
        for (int c = 2; c <= 20; c++) begin
            blank_nxt = (c <= 4) || (c >= 9 && c <= 12);
            step(1, 0, 0, 10, 1, 0, 0, 14, "fl_cyc");
        end
        blank_nxt = 1'b0;
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
